// File: rtl/gpio_ctrl.sv
// GPIO controller: output/direction registers, synchronised inputs,
// per-pin rise/fall edge interrupts with sticky pending bits, and a
// simple one-cycle-latency register bus.
module gpio_ctrl #(
  parameter int unsigned WIDTH       = 8,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sel,
  input  logic             we,
  input  logic [2:0]       addr,
  input  logic [31:0]      wdata,
  output logic [31:0]      rdata,
  output logic             ready,
  input  logic [WIDTH-1:0] gpio_in,
  output logic [WIDTH-1:0] gpio_out,
  output logic [WIDTH-1:0] gpio_oe,
  output logic             irq
);

  typedef enum logic [2:0] {
    REG_OUT     = 3'd0,
    REG_DIR     = 3'd1,
    REG_IN      = 3'd2,
    REG_RISE_EN = 3'd3,
    REG_FALL_EN = 3'd4,
    REG_PEND    = 3'd5,
    REG_SET     = 3'd6,
    REG_CLR     = 3'd7
  } reg_e;

  logic [WIDTH-1:0] out_q, out_d;
  logic [WIDTH-1:0] dir_q, dir_d;
  logic [WIDTH-1:0] rise_en_q, rise_en_d;
  logic [WIDTH-1:0] fall_en_q, fall_en_d;
  logic [WIDTH-1:0] pend_q, pend_d;
  logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q, sync_d;
  logic [WIDTH-1:0] dly_q, dly_d;
  logic [31:0]      rdata_q, rdata_d;
  logic             ready_q, ready_d;
  logic             irq_q, irq_d;

  logic [WIDTH-1:0] wd;
  logic [WIDTH-1:0] in_sync;
  logic [WIDTH-1:0] rise, fall, pend_clr, rd_val;
  logic             acc_rd, acc_wr;
  reg_e             reg_sel;
  // Write data bits at or above WIDTH are intentionally discarded.
  logic             unused_wdata;

  assign unused_wdata = ^wdata;
  assign gpio_out = out_q;
  assign gpio_oe  = dir_q;
  assign rdata    = rdata_q;
  assign ready    = ready_q;
  assign irq      = irq_q;

  // Input synchroniser shift and edge-delay copy.
  always_comb begin
    sync_d    = sync_q;
    sync_d[0] = gpio_in;
    for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
      sync_d[i] = sync_q[i-1];
    end
    in_sync = sync_q[SYNC_STAGES-1];
    dly_d   = in_sync;
    rise    = in_sync & ~dly_q;
    fall    = ~in_sync & dly_q;
  end

  // Register writes, pending-bit update, read mux and bus handshake.
  always_comb begin
    reg_sel   = reg_e'(addr);
    acc_rd    = sel & ~we;
    acc_wr    = sel & we;
    wd        = wdata[WIDTH-1:0];
    out_d     = out_q;
    dir_d     = dir_q;
    rise_en_d = rise_en_q;
    fall_en_d = fall_en_q;
    pend_clr  = '0;
    if (acc_wr) begin
      case (reg_sel)
        REG_OUT:     out_d     = wd;
        REG_DIR:     dir_d     = wd;
        REG_RISE_EN: rise_en_d = wd;
        REG_FALL_EN: fall_en_d = wd;
        REG_PEND:    pend_clr  = wd;
        REG_SET:     out_d     = out_q | wd;
        REG_CLR:     out_d     = out_q & ~wd;
        default:     ;
      endcase
    end
    // New events are OR-ed after the clear so a coincident set wins.
    pend_d = (pend_q & ~pend_clr) | (rise & rise_en_q) | (fall & fall_en_q);
    irq_d  = |pend_q;

    rd_val = '0;
    case (reg_sel)
      REG_OUT:     rd_val = out_q;
      REG_DIR:     rd_val = dir_q;
      REG_IN:      rd_val = in_sync;
      REG_RISE_EN: rd_val = rise_en_q;
      REG_FALL_EN: rd_val = fall_en_q;
      REG_PEND:    rd_val = pend_q;
      default:     rd_val = '0;
    endcase
    rdata_d = rdata_q;
    if (acc_rd) begin
      rdata_d             = '0;
      rdata_d[WIDTH-1:0]  = rd_val;
    end
    ready_d = sel;
  end

  // State registers with synchronous reset overriding any access.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_q     <= '0;
      dir_q     <= '0;
      rise_en_q <= '0;
      fall_en_q <= '0;
      pend_q    <= '0;
      sync_q    <= '0;
      dly_q     <= '0;
      rdata_q   <= '0;
      ready_q   <= 1'b0;
      irq_q     <= 1'b0;
    end else begin
      out_q     <= out_d;
      dir_q     <= dir_d;
      rise_en_q <= rise_en_d;
      fall_en_q <= fall_en_d;
      pend_q    <= pend_d;
      sync_q    <= sync_d;
      dly_q     <= dly_d;
      rdata_q   <= rdata_d;
      ready_q   <= ready_d;
      irq_q     <= irq_d;
    end
  end

endmodule

// File: tb/tb_gpio_ctrl.sv
// Directed self-checking bench for gpio_ctrl (WIDTH=8 main instance,
// WIDTH=4 instance sharing the bus for width-masking checks).
module tb_gpio_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        sel = 1'b0;
  logic        we = 1'b0;
  logic [2:0]  addr = 3'd0;
  logic [31:0] wdata = 32'd0;
  logic [31:0] rdata, rdata4;
  logic        ready, ready4;
  logic [7:0]  gpio_in = 8'h00;
  logic [7:0]  gpio_out, gpio_oe;
  logic [3:0]  gpio_in4 = 4'h0;
  logic [3:0]  gpio_out4, gpio_oe4;
  logic        irq, irq4;

  int tests = 0;
  int fails = 0;

  gpio_ctrl #(.WIDTH(8), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst(rst), .sel(sel), .we(we), .addr(addr), .wdata(wdata),
    .rdata(rdata), .ready(ready), .gpio_in(gpio_in), .gpio_out(gpio_out),
    .gpio_oe(gpio_oe), .irq(irq)
  );

  gpio_ctrl #(.WIDTH(4), .SYNC_STAGES(2)) dut4 (
    .clk(clk), .rst(rst), .sel(sel), .we(we), .addr(addr), .wdata(wdata),
    .rdata(rdata4), .ready(ready4), .gpio_in(gpio_in4), .gpio_out(gpio_out4),
    .gpio_oe(gpio_oe4), .irq(irq4)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got running expected done");
    $fatal(1, "timeout");
  end

  task automatic bus_wr(input logic [2:0] a, input logic [31:0] d);
    @(negedge clk);
    sel = 1'b1; we = 1'b1; addr = a; wdata = d;
    @(negedge clk);
    sel = 1'b0; we = 1'b0;
  endtask

  task automatic bus_rd(input logic [2:0] a, output logic [31:0] rd,
                        output logic rdy, output logic [31:0] rd4);
    @(negedge clk);
    sel = 1'b1; we = 1'b0; addr = a;
    @(negedge clk);
    sel = 1'b0;
    rd = rdata; rdy = ready; rd4 = rdata4;
  endtask

  task automatic test_reset;
    repeat (2) @(negedge clk);
    tests++; if (gpio_out !== 8'h00) begin fails++; $display("FAIL reset_out: got %h expected 00", gpio_out); end
    tests++; if (gpio_oe !== 8'h00) begin fails++; $display("FAIL reset_oe: got %h expected 00", gpio_oe); end
    tests++; if (ready !== 1'b0) begin fails++; $display("FAIL reset_ready: got %b expected 0", ready); end
    tests++; if (rdata !== 32'h0) begin fails++; $display("FAIL reset_rdata: got %h expected 0", rdata); end
    tests++; if (irq !== 1'b0) begin fails++; $display("FAIL reset_irq: got %b expected 0", irq); end
    rst = 1'b0;
  endtask

  task automatic test_width4;
    logic [31:0] rd, rd4; logic rdy;
    bus_wr(3'd0, 32'hFFFF_FFFF);
    tests++; if (gpio_out4 !== 4'hF) begin fails++; $display("FAIL w4_gpio_out: got %h expected F", gpio_out4); end
    bus_rd(3'd0, rd, rdy, rd4);
    tests++; if (rd4 !== 32'h0000_000F) begin fails++; $display("FAIL w4_read_out: got %h expected 0000000f", rd4); end
    tests++; if (rd !== 32'h0000_00FF) begin fails++; $display("FAIL w8_read_out: got %h expected 000000ff", rd); end
    bus_rd(3'd6, rd, rdy, rd4);
    tests++; if (rd4 !== 32'h0) begin fails++; $display("FAIL w4_read_set: got %h expected 0", rd4); end
    tests++; if (rd !== 32'h0) begin fails++; $display("FAIL w8_read_set: got %h expected 0", rd); end
  endtask

  task automatic test_out_dir;
    logic [31:0] rd, rd4; logic rdy;
    bus_wr(3'd1, 32'h0000_00FF);
    bus_wr(3'd0, 32'h0000_00A5);
    tests++; if (gpio_oe !== 8'hFF) begin fails++; $display("FAIL dir_oe: got %h expected ff", gpio_oe); end
    tests++; if (gpio_out !== 8'hA5) begin fails++; $display("FAIL out_value: got %h expected a5", gpio_out); end
    bus_rd(3'd0, rd, rdy, rd4);
    tests++; if (rd !== 32'h0000_00A5) begin fails++; $display("FAIL read_out: got %h expected 000000a5", rd); end
    tests++; if (rdy !== 1'b1) begin fails++; $display("FAIL read_ready: got %b expected 1", rdy); end
    @(negedge clk);
    tests++; if (ready !== 1'b0) begin fails++; $display("FAIL ready_drop: got %b expected 0", ready); end
    tests++; if (rdata !== 32'h0000_00A5) begin fails++; $display("FAIL rdata_hold: got %h expected 000000a5", rdata); end
    bus_wr(3'd3, 32'h0000_0000);
    tests++; if (ready !== 1'b1) begin fails++; $display("FAIL write_ready: got %b expected 1", ready); end
    tests++; if (rdata !== 32'h0000_00A5) begin fails++; $display("FAIL write_keeps_rdata: got %h expected 000000a5", rdata); end
  endtask

  task automatic test_set_clr;
    logic [31:0] rd, rd4; logic rdy;
    bus_wr(3'd6, 32'h0000_000A);
    tests++; if (gpio_out !== 8'hAF) begin fails++; $display("FAIL set_out: got %h expected af", gpio_out); end
    bus_wr(3'd7, 32'h0000_0081);
    tests++; if (gpio_out !== 8'h2E) begin fails++; $display("FAIL clr_out: got %h expected 2e", gpio_out); end
    bus_rd(3'd7, rd, rdy, rd4);
    tests++; if (rd !== 32'h0) begin fails++; $display("FAIL read_clr: got %h expected 0", rd); end
  endtask

  task automatic test_in;
    logic [31:0] rd, rd4; logic rdy;
    gpio_in = 8'h5A;
    repeat (3) @(negedge clk);
    bus_rd(3'd2, rd, rdy, rd4);
    tests++; if (rd !== 32'h0000_005A) begin fails++; $display("FAIL read_in: got %h expected 0000005a", rd); end
    gpio_in = 8'h00;
    repeat (4) @(negedge clk);
    tests++; if (irq !== 1'b0) begin fails++; $display("FAIL no_enable_irq: got %b expected 0", irq); end
  endtask

  task automatic test_rise_edge;
    logic [31:0] rd, rd4; logic rdy;
    bus_wr(3'd3, 32'h0000_0001);
    @(negedge clk);
    gpio_in = 8'h01;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      tests++;
      if (irq !== (k == 4)) begin
        fails++; $display("FAIL rise_irq_timing[%0d]: got %b expected %b", k, irq, (k == 4));
      end
    end
    bus_rd(3'd5, rd, rdy, rd4);
    tests++; if (rd !== 32'h0000_0001) begin fails++; $display("FAIL rise_pend: got %h expected 00000001", rd); end
    bus_wr(3'd5, 32'h0000_0001);
    tests++; if (irq !== 1'b1) begin fails++; $display("FAIL irq_lag: got %b expected 1", irq); end
    @(negedge clk);
    tests++; if (irq !== 1'b0) begin fails++; $display("FAIL pend_clear_irq: got %b expected 0", irq); end
    gpio_in = 8'h00;
    repeat (6) @(negedge clk);
    tests++; if (irq !== 1'b0) begin fails++; $display("FAIL fall_ignored_irq: got %b expected 0", irq); end
    bus_rd(3'd5, rd, rdy, rd4);
    tests++; if (rd !== 32'h0) begin fails++; $display("FAIL fall_ignored_pend: got %h expected 0", rd); end
  endtask

  task automatic test_set_wins;
    logic [31:0] rd, rd4; logic rdy;
    @(negedge clk);
    gpio_in = 8'h01;
    repeat (5) @(negedge clk);
    tests++; if (irq !== 1'b1) begin fails++; $display("FAIL prewin_irq: got %b expected 1", irq); end
    gpio_in = 8'h00;
    repeat (4) @(negedge clk);
    gpio_in = 8'h01;
    @(negedge clk);
    @(negedge clk);
    sel = 1'b1; we = 1'b1; addr = 3'd5; wdata = 32'h0000_0001;
    @(negedge clk);
    sel = 1'b0; we = 1'b0;
    tests++; if (irq !== 1'b1) begin fails++; $display("FAIL setwin_irq0: got %b expected 1", irq); end
    @(negedge clk);
    tests++; if (irq !== 1'b1) begin fails++; $display("FAIL setwin_irq1: got %b expected 1", irq); end
    bus_rd(3'd5, rd, rdy, rd4);
    tests++; if (rd !== 32'h0000_0001) begin fails++; $display("FAIL setwin_pend: got %h expected 00000001", rd); end
  endtask

  task automatic test_back_to_back;
    @(negedge clk);
    sel = 1'b1; we = 1'b1; addr = 3'd0; wdata = 32'h0000_003C;
    @(negedge clk);
    we = 1'b0; addr = 3'd0;
    tests++; if (ready !== 1'b1) begin fails++; $display("FAIL b2b_wr_ready: got %b expected 1", ready); end
    @(negedge clk);
    addr = 3'd1;
    tests++; if (ready !== 1'b1) begin fails++; $display("FAIL b2b_rd0_ready: got %b expected 1", ready); end
    tests++; if (rdata !== 32'h0000_003C) begin fails++; $display("FAIL b2b_rd0_data: got %h expected 0000003c", rdata); end
    @(negedge clk);
    sel = 1'b0;
    tests++; if (ready !== 1'b1) begin fails++; $display("FAIL b2b_rd1_ready: got %b expected 1", ready); end
    tests++; if (rdata !== 32'h0000_00FF) begin fails++; $display("FAIL b2b_rd1_data: got %h expected 000000ff", rdata); end
    @(negedge clk);
    tests++; if (ready !== 1'b0) begin fails++; $display("FAIL b2b_idle_ready: got %b expected 0", ready); end
    tests++; if (rdata !== 32'h0000_00FF) begin fails++; $display("FAIL b2b_idle_hold: got %h expected 000000ff", rdata); end
  endtask

  task automatic test_reset_during_access;
    logic [31:0] rd, rd4; logic rdy;
    @(negedge clk);
    rst = 1'b1; sel = 1'b1; we = 1'b0; addr = 3'd5;
    @(negedge clk);
    tests++; if (ready !== 1'b0) begin fails++; $display("FAIL rst_acc_ready: got %b expected 0", ready); end
    tests++; if (rdata !== 32'h0) begin fails++; $display("FAIL rst_acc_rdata: got %h expected 0", rdata); end
    tests++; if (irq !== 1'b0) begin fails++; $display("FAIL rst_acc_irq: got %b expected 0", irq); end
    tests++; if (gpio_out !== 8'h00) begin fails++; $display("FAIL rst_acc_out: got %h expected 00", gpio_out); end
    // Pin 0 stays high across reset; enable rise immediately after release.
    rst = 1'b0; sel = 1'b1; we = 1'b1; addr = 3'd3; wdata = 32'h0000_0001;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      sel = 1'b0; we = 1'b0;
      tests++;
      if (irq !== (k == 4)) begin
        fails++; $display("FAIL post_rst_rise[%0d]: got %b expected %b", k, irq, (k == 4));
      end
    end
    bus_wr(3'd5, 32'h0000_0001);
    repeat (3) @(negedge clk);
    bus_rd(3'd5, rd, rdy, rd4);
    tests++; if (rd !== 32'h0) begin fails++; $display("FAIL single_rise_event: got %h expected 0", rd); end
  endtask

  initial begin
    test_reset;
    test_width4;
    test_out_dir;
    test_set_clr;
    test_in;
    test_rise_edge;
    test_set_wins;
    test_back_to_back;
    test_reset_during_access;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/gpio_ctrl.md
GPIO_CTRL -- requirements
Module: gpio_ctrl

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, number of GPIO pins (legal 1..32).
REQ-002 The block SHALL have parameter SYNC_STAGES, default 2, input synchroniser depth (legal 2..4).
REQ-003 The block SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 The block SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 The block SHALL have port sel  input  1  bus access request, one-cycle strobe.
REQ-006 The block SHALL have port we  input  1  1 = write, 0 = read; sampled with sel.
REQ-007 The block SHALL have port addr  input  3  word register index.
REQ-008 The block SHALL have port wdata  input  32  write data.
REQ-009 The block SHALL have port rdata  output  32  registered read data.
REQ-010 The block SHALL have port ready  output  1  one-cycle access acknowledge.
REQ-011 The block SHALL have port gpio_in  input  WIDTH  asynchronous pin inputs.
REQ-012 The block SHALL have port gpio_out  output  WIDTH  pin output values.
REQ-013 The block SHALL have port gpio_oe  output  WIDTH  per-pin output enable, 1 = drive.
REQ-014 The block SHALL have port irq  output  1  level interrupt request.

Function
REQ-015 Register map SHALL be: 0 OUT (rw), 1 DIR (rw), 2 IN (ro), 3 RISE_EN (rw), 4 FALL_EN (rw), 5 PEND (read, write-1-to-clear), 6 SET (wo), 7 CLR (wo).
REQ-016 gpio_out SHALL equal OUT and gpio_oe SHALL equal DIR combinationally from registers, no extra delay.
REQ-017 gpio_in SHALL pass through a SYNC_STAGES flop chain; IN SHALL read the last stage.
REQ-018 An edge detector SHALL compare last stage with one further delayed copy; rise = new 1 & old 0, fall = new 0 & old 1.
REQ-019 PEND[i] SHALL set on (rise[i] & RISE_EN[i]) | (fall[i] & FALL_EN[i]) and remain set until cleared.
REQ-020 Writing PEND SHALL clear bits where wdata is 1; if set and clear coincide on a bit in the same cycle, set SHALL win.
REQ-021 Writing SET SHALL OR wdata into OUT; writing CLR SHALL AND ~wdata into OUT; OUT/DIR writes replace the register.
REQ-022 irq SHALL be registered: irq = |PEND, updating one cycle after PEND changes.
REQ-023 Access latency SHALL be fixed: sel in cycle N -> ready=1 and rdata valid in cycle N+1; ready SHALL be 0 otherwise.
REQ-024 rdata SHALL read 0 for SET, CLR, and for any bit at or above WIDTH; write bits above WIDTH SHALL be ignored.
REQ-025 rdata SHALL hold its last value when no read completes; write accesses SHALL not change rdata.
REQ-026 Back-to-back sel on consecutive cycles SHALL each be accepted and acknowledged in order.
REQ-027 Edge detection SHALL operate regardless of DIR; pins configured as outputs still report IN.

Reset
REQ-028 On rst, OUT, DIR, RISE_EN, FALL_EN, PEND, rdata, ready, irq SHALL become 0; synchroniser and edge flops SHALL load 0.
REQ-029 rst SHALL override any concurrent access; an access in the reset cycle SHALL be dropped with no ready.
REQ-030 After rst deassert, a pin held high SHALL produce one rise event once it reaches the detector stage.

Verification
REQ-031 Reset, then write DIR=0xFF, OUT=0xA5 -> gpio_oe=0xFF, gpio_out=0xA5; read OUT next cycle gives rdata=0x000000A5, ready=1 one cycle after sel.
REQ-032 OUT=0xA5; write SET=0x0A, then CLR=0x81 -> gpio_out 0xAF then 0x2E.
REQ-033 RISE_EN=0x01, gpio_in[0] 0->1 at cycle T -> PEND[0]=1 at T+SYNC_STAGES+1, irq=1 one cycle later; FALL edge ignored.
REQ-034 PEND[0]=1, write PEND=0x01 in the same cycle a new enabled edge on bit 0 sets it -> PEND[0] stays 1, irq stays 1.
REQ-035 WIDTH=4 build: write OUT=0xFFFFFFFF -> read OUT returns 0x0000000F; read SET returns 0.
REQ-036 Assert rst during a read with PEND nonzero -> next cycle ready=0, rdata=0, PEND=0, irq=0.
